// File: rtl/lane_pack_fifo.sv
// Width-converting lane FIFO: packs variable-count input beats into a lane ring buffer
// and pops fixed-width output words, optionally rate-limited by a free-running read strobe.
module lane_pack_fifo #(
    parameter int unsigned LANE_W      = 64,
    parameter int unsigned IN_LANES    = 2,
    parameter int unsigned OUT_LANES   = 3,
    parameter int unsigned DEPTH_LANES = 1024,
    parameter int unsigned RD_DIV      = 30,
    parameter int unsigned THRESH      = 512
) (
    input  logic                              clk,
    input  logic                              rstn,
    input  logic                              flush,
    input  logic                              wr,
    input  logic [$clog2(IN_LANES+1)-1:0]     wr_cnt,
    input  logic [IN_LANES*LANE_W-1:0]        data_in,
    input  logic                              rd,
    output logic [OUT_LANES*LANE_W-1:0]       data_out,
    output logic                              data_out_valid,
    output logic [$clog2(DEPTH_LANES):0]      level,
    output logic                              full,
    output logic                              empty,
    output logic                              threshold,
    output logic                              overflow,
    output logic                              underflow
);

    localparam int unsigned PTR_W = $clog2(DEPTH_LANES);
    localparam int unsigned LVL_W = PTR_W + 1;
    localparam int unsigned CNT_W = $clog2(IN_LANES + 1);
    localparam int unsigned RD_W  = (RD_DIV > 1) ? $clog2(RD_DIV) : 1;

    logic [LANE_W-1:0]            mem [DEPTH_LANES];
    logic [PTR_W-1:0]             wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]             rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]             level_q, level_d;
    logic [RD_W-1:0]              rate_q, rate_d;
    logic [OUT_LANES*LANE_W-1:0]  dout_q, dout_d;
    logic [OUT_LANES*LANE_W-1:0]  rd_word;
    logic                         dval_q, dval_d;
    logic                         ovf_q, ovf_d;
    logic                         udf_q, udf_d;
    logic [CNT_W-1:0]             cnt_eff;
    logic                         tick;
    logic                         wr_en;
    logic                         rd_en;

    always_comb begin
        cnt_eff   = (wr_cnt > CNT_W'(IN_LANES)) ? CNT_W'(IN_LANES) : wr_cnt;
        full      = (LVL_W'(DEPTH_LANES) - level_q) < LVL_W'(IN_LANES);
        empty     = level_q < LVL_W'(OUT_LANES);
        threshold = level_q >= LVL_W'(THRESH);
        tick      = (rate_q == RD_W'(RD_DIV - 1));
        wr_en     = wr & ~full & (wr_cnt != '0) & ~flush;
        rd_en     = rd & tick & ~empty & ~flush;
    end

    // First lane popped goes to the MSB lane of the output word.
    always_comb begin
        rd_word = '0;
        for (int unsigned k = 0; k < OUT_LANES; k++) begin
            rd_word[(OUT_LANES-1-k)*LANE_W +: LANE_W] = mem[rd_ptr_q + PTR_W'(k)];
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        dout_d   = dout_q;
        dval_d   = 1'b0;
        ovf_d    = ovf_q;
        udf_d    = udf_q;
        rate_d   = tick ? '0 : rate_q + RD_W'(1);
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
            ovf_d    = 1'b0;
            udf_d    = 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(cnt_eff);
            end
            if (rd_en) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(OUT_LANES);
                dout_d   = rd_word;
            end
            dval_d  = rd_en;
            level_d = level_q + (wr_en ? LVL_W'(cnt_eff) : '0)
                              - (rd_en ? LVL_W'(OUT_LANES) : '0);
            ovf_d   = ovf_q | (wr & (wr_cnt != '0) & full);
            udf_d   = udf_q | (rd & tick & empty);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            rate_q   <= '0;
            dout_q   <= '0;
            dval_q   <= 1'b0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            rate_q   <= rate_d;
            dout_q   <= dout_d;
            dval_q   <= dval_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    // Storage is not reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int unsigned i = 0; i < IN_LANES; i++) begin
                if (CNT_W'(i) < cnt_eff) begin
                    mem[wr_ptr_q + PTR_W'(i)] <= data_in[(IN_LANES-1-i)*LANE_W +: LANE_W];
                end
            end
        end
    end

    assign data_out       = dout_q;
    assign data_out_valid = dval_q;
    assign level          = level_q;
    assign overflow       = ovf_q;
    assign underflow      = udf_q;

endmodule

// File: tb/tb_lane_pack_fifo.sv
// Bench for lane_pack_fifo: queue-of-lanes reference model with a scoreboard of expected
// output words; one instance reads every cycle, a second uses the default read divider.
module tb_lane_pack_fifo;

    localparam int DEPTH = 1024;
    localparam int INL   = 2;
    localparam int OUTL  = 3;
    localparam int F_DIV = 1;
    localparam int S_DIV = 30;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    logic         f_flush = 0, f_wr = 0, f_rd = 0;
    logic [1:0]   f_cnt = 0;
    logic [127:0] f_din = '0;
    logic [191:0] f_dout;
    logic         f_dval, f_full, f_empty, f_thr, f_ovf, f_udf;
    logic [10:0]  f_level;

    logic         s_flush = 0, s_wr = 0, s_rd = 0;
    logic [1:0]   s_cnt = 0;
    logic [127:0] s_din = '0;
    logic [191:0] s_dout;
    logic         s_dval, s_full, s_empty, s_thr, s_ovf, s_udf;
    logic [10:0]  s_level;

    lane_pack_fifo #(.LANE_W(64), .IN_LANES(2), .OUT_LANES(3), .DEPTH_LANES(1024),
                     .RD_DIV(F_DIV), .THRESH(512)) u_fast (
        .clk(clk), .rstn(rstn), .flush(f_flush), .wr(f_wr), .wr_cnt(f_cnt), .data_in(f_din),
        .rd(f_rd), .data_out(f_dout), .data_out_valid(f_dval), .level(f_level), .full(f_full),
        .empty(f_empty), .threshold(f_thr), .overflow(f_ovf), .underflow(f_udf));

    lane_pack_fifo #(.LANE_W(64), .IN_LANES(2), .OUT_LANES(3), .DEPTH_LANES(1024),
                     .RD_DIV(S_DIV), .THRESH(512)) u_slow (
        .clk(clk), .rstn(rstn), .flush(s_flush), .wr(s_wr), .wr_cnt(s_cnt), .data_in(s_din),
        .rd(s_rd), .data_out(s_dout), .data_out_valid(s_dval), .level(s_level), .full(s_full),
        .empty(s_empty), .threshold(s_thr), .overflow(s_ovf), .underflow(s_udf));

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model: the FIFO is a queue of lanes; popped words go to the scoreboard.
    logic [63:0]  mq[$];
    logic [191:0] eq[$];
    logic [191:0] m_dout = '0;
    logic [191:0] m_w;
    bit           m_ovf = 0, m_udf = 0, m_dval = 0;
    bit           m_full, m_empty, m_tick, m_rde;
    int           m_rate = 0, m_lvl, m_n, m_lanes_in = 0;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mq.delete();
            eq.delete();
            m_ovf = 0; m_udf = 0; m_dval = 0; m_dout = '0; m_rate = 0;
        end else begin
            m_lvl   = mq.size();
            m_full  = (DEPTH - m_lvl) < INL;
            m_empty = m_lvl < OUTL;
            m_tick  = (m_rate == F_DIV - 1);
            m_n     = (f_cnt > 2'(INL)) ? INL : int'(f_cnt);
            m_rde   = 0;
            if (f_flush) begin
                mq.delete();
                m_ovf = 0; m_udf = 0;
            end else begin
                if (f_wr && f_cnt != 0 && m_full) m_ovf = 1;
                if (f_rd && m_tick && m_empty) m_udf = 1;
                if (f_rd && m_tick && !m_empty) begin
                    m_rde = 1;
                    m_w[191:128] = mq.pop_front();
                    m_w[127:64]  = mq.pop_front();
                    m_w[63:0]    = mq.pop_front();
                    eq.push_back(m_w);
                    m_dout = m_w;
                end
                if (f_wr && !m_full && m_n > 0) begin
                    for (int j = 0; j < m_n; j++) mq.push_back(f_din[(1-j)*64 +: 64]);
                    m_lanes_in += m_n;
                end
            end
            m_dval = m_rde;
            m_rate = m_tick ? 0 : m_rate + 1;
        end
    end

    logic [191:0] mon_w;
    int           mon_l;
    always @(negedge clk) begin
        if (rstn) begin
            mon_l = mq.size();
            chk("level", 192'(f_level), 192'(mon_l));
            chk("flags", {f_full, f_empty, f_thr, f_ovf, f_udf},
                {(DEPTH - mon_l) < INL, mon_l < OUTL, mon_l >= 512, m_ovf, m_udf});
            chk("valid", f_dval, m_dval);
            if (f_dval) begin
                if (eq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL word: got %0h expected no output", f_dout);
                end else begin
                    mon_w = eq.pop_front();
                    chk("word", f_dout, mon_w);
                end
            end
            chk("dout_hold", f_dout, m_dout);
        end
    end

    // Slow instance: scoreboard of words plus pop spacing and underflow timing.
    logic [191:0] s_eq[$];
    logic [191:0] s_w;
    int s_cyc = 0, s_pops = 0, s_last = 0, s_t_last = -100;
    bit s_udf_seen = 0;
    always @(negedge clk) begin
        if (rstn) begin
            s_cyc++;
            if (s_dval) begin
                if (s_eq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rate_word: got %0h expected no output", s_dout);
                end else begin
                    s_w = s_eq.pop_front();
                    chk("rate_word", s_dout, s_w);
                end
                if (s_pops > 0) chk("rate_interval", 192'(s_cyc - s_last), 192'(S_DIV));
                chk("rate_no_udf", s_udf, 1'b0);
                s_last = s_cyc;
                s_pops++;
                if (s_pops == 30) s_t_last = s_cyc;
            end
            if (s_cyc == s_t_last + S_DIV - 1) begin
                chk("rate_pre_udf", {s_udf, s_empty}, 2'b01);
                chk("rate_no_extra_pop", s_dval, 1'b0);
            end
            if (s_cyc == s_t_last + S_DIV) begin
                chk("rate_udf", {s_udf, s_empty}, 2'b11);
                s_udf_seen = 1;
            end
        end
    end

    task automatic step(input logic w, input logic [1:0] c, input logic [127:0] d,
                        input logic r, input logic fl);
        f_wr = w; f_cnt = c; f_din = d; f_rd = r; f_flush = fl;
        @(posedge clk); #1;
        f_wr = 0; f_cnt = 0; f_rd = 0; f_flush = 0;
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    logic [63:0]  a1, a0, b1, b0, seq;
    logic [63:0]  sl [90];
    int           wp, rp, budget;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state while held
        repeat (3) @(posedge clk);
        #1;
        chk("rst_level", f_level, 11'd0);
        chk("rst_flags", {f_full, f_empty, f_thr, f_ovf, f_udf}, 5'b01000);
        chk("rst_dout", {f_dval, f_dout}, '0);
        rstn = 1;
        step(0, 0, '0, 0, 0);

        // Pack ordering
        a1 = 64'hA1A1_0000_0000_00A1; a0 = 64'hA0A0_0000_0000_00A0;
        b1 = 64'hB1B1_0000_0000_00B1; b0 = 64'hB0B0_0000_0000_00B0;
        step(1, 1, {a1, a0}, 0, 0);
        step(1, 2, {b1, b0}, 0, 0);
        chk("pack_level3", f_level, 11'd3);
        step(0, 0, '0, 1, 0);
        chk("pack_word", {f_dval, f_dout}, {1'b1, a1, b1, b0});
        chk("pack_level0", f_level, 11'd0);
        step(0, 0, '0, 0, 0);
        chk("pack_pulse", f_dval, 1'b0);

        // Fill to full, overflow, simultaneous read at full
        for (int i = 0; i < 511; i++) step(1, 2, rnd128(), 0, 0);
        chk("full_511", {f_level, f_full}, {11'd1022, 1'b0});
        step(1, 2, rnd128(), 0, 0);
        chk("full_512", {f_level, f_full}, {11'd1024, 1'b1});
        step(1, 2, rnd128(), 0, 0);
        chk("full_ovf", {f_level, f_ovf}, {11'd1024, 1'b1});
        step(1, 2, rnd128(), 1, 0);
        chk("full_rd_wr", {f_level, f_full, f_dval}, {11'd1021, 1'b0, 1'b1});
        step(0, 0, '0, 0, 1);
        chk("flush_clear", {f_level, f_ovf, f_empty}, {11'd0, 1'b0, 1'b1});
        step(0, 0, '0, 1, 0);
        chk("udf_set", f_udf, 1'b1);

        // Flush at 700 with wr and rd asserted
        for (int i = 0; i < 350; i++) step(1, 2, rnd128(), 0, 0);
        chk("fl_level700", f_level, 11'd700);
        step(1, 2, rnd128(), 1, 1);
        chk("fl_after", {f_level, f_empty, f_ovf, f_udf, f_dval}, {11'd0, 4'b1000});
        step(0, 0, '0, 0, 0);
        chk("fl_nowrite", f_level, 11'd0);

        // Random streaming across the wrap, fill-biased then drain-biased
        seq = 64'd1;
        m_lanes_in = 0;
        for (int n = 0; n < 20000 && m_lanes_in < 1400; n++) begin
            step($urandom_range(99) < 90, 2'($urandom_range(3)), {seq, seq + 64'd1},
                 $urandom_range(99) < 30, 0);
            seq += 64'd2;
        end
        chk("wrap_budget_a", m_lanes_in >= 1400, 1'b1);
        for (int n = 0; n < 20000 && m_lanes_in < 2600; n++) begin
            step($urandom_range(99) < 50, 2'($urandom_range(3)), {seq, seq + 64'd1},
                 $urandom_range(99) < 90, 0);
            seq += 64'd2;
        end
        chk("wrap_budget_b", m_lanes_in >= 2600, 1'b1);
        budget = 0;
        while (mq.size() >= OUTL && budget < 2000) begin
            step(0, 0, '0, 1, 0);
            budget++;
        end
        step(0, 0, '0, 0, 0);
        chk("wrap_drained", {mq.size() < OUTL, eq.size() == 0}, 2'b11);

        // Mid-traffic asynchronous reset
        step(0, 0, '0, 1, 0);
        for (int i = 0; i < 5; i++) step(1, 2, rnd128(), $urandom_range(1), 0);
        #3 rstn = 0;
        #1;
        chk("mid_rst_level", f_level, 11'd0);
        chk("mid_rst_flags", {f_full, f_empty, f_ovf, f_udf}, 4'b0100);
        chk("mid_rst_dout", {f_dval, f_dout}, '0);
        @(posedge clk); #1;
        rstn = 1;

        // Rate-limited reads on the slow instance: 90 lanes -> 30 pops, 30 cycles apart
        for (int i = 0; i < 90; i++) sl[i] = 64'h5100_0000_0000_0000 + 64'(i);
        for (int i = 0; i < 30; i++) s_eq.push_back({sl[3*i], sl[3*i+1], sl[3*i+2]});
        for (int k = 0; k < 45; k++) begin
            s_wr = 1; s_cnt = 2; s_din = {sl[2*k], sl[2*k+1]};
            @(posedge clk); #1;
        end
        s_wr = 0; s_cnt = 0;
        chk("rate_level90", {s_level, s_udf}, {11'd90, 1'b0});
        s_rd = 1;
        budget = 0;
        while (s_pops < 30 && budget < 30 * 35) begin
            @(posedge clk); #1;
            budget++;
        end
        repeat (S_DIV + 3) @(posedge clk);
        #1;
        s_rd = 0;
        chk("rate_pops", 192'(s_pops), 192'(30));
        chk("rate_udf_seen", s_udf_seen, 1'b1);
        chk("rate_sb_empty", s_eq.size() == 0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
